// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared encodings for the unified memory arbiter
package unified_mem_pkg;

    localparam int AW_DEFAULT = 6;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_RESP = 2'd1,
        ST_D_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - core-side and RAM-side signals of the unified memory arbiter
interface unified_mem_arbiter_if
    import unified_mem_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) ();
    logic          if_req;
    logic [31:0]   if_addr;
    logic [31:0]   if_rdata;
    logic          if_valid;
    logic          d_rd;
    logic          d_wr;
    logic [31:0]   d_addr;
    logic [1:0]    d_size;
    logic          d_signed;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_valid;
    logic          d_err;
    logic          stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_size, d_signed, d_wdata, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_valid, d_err, stall,
               mem_en, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_size, d_signed, d_wdata, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid, d_err, stall,
               mem_en, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter_lsu_align.sv
// rtl/unified_mem_arbiter_lsu_align.sv - sub-word alignment: legality, byte enables, store replication, load extend
module lsu_align
    import unified_mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic        o_misaligned,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shifted;

    always_comb begin
        o_misaligned = 1'b0;
        o_be         = 4'b0000;
        o_wdata      = 32'h0;
        o_rdata      = 32'h0;
        w_shifted    = i_rdata >> {i_addr_lo, 3'b000};
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                o_misaligned = i_addr_lo[0];
                o_be         = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            end
            SZ_WORD: begin
                o_misaligned = |i_addr_lo;
                o_be         = 4'b1111;
                o_wdata      = i_wdata;
                o_rdata      = w_shifted;
            end
            default: o_misaligned = 1'b1;
        endcase
    end
endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port RAM between instruction fetch and load/store
module unified_mem_arbiter
    import unified_mem_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.slave  bus
);
    state_e        r_state;
    state_e        w_next;
    logic [1:0]    r_addr_lo;
    logic [1:0]    r_size;
    logic          r_signed;
    logic          r_err;
    logic          r_is_load;

    logic          w_d_req;
    logic          w_iss_mis;
    logic [3:0]    w_iss_be;
    logic [31:0]   w_iss_wdata;
    logic [31:0]   w_rsp_rdata;
    logic [31:0]   w_unused_iss_rdata;
    logic          w_unused_rsp_mis;
    logic [3:0]    w_unused_rsp_be;
    logic [31:0]   w_unused_rsp_wdata;
    logic          w_unused_addr;

    logic          w_mem_en;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [3:0]    w_mem_be;
    logic [31:0]   w_mem_wdata;
    logic          w_if_valid;
    logic [31:0]   w_if_rdata;
    logic          w_d_valid;
    logic          w_d_err;
    logic [31:0]   w_d_rdata;

    assign w_d_req       = bus.d_rd | bus.d_wr;
    // Address bits above the RAM size are dropped so accesses wrap.
    assign w_unused_addr = ^{bus.d_addr[31:AW+2], bus.if_addr[31:AW+2], bus.if_addr[1:0]};

    lsu_align u_issue (
        .i_addr_lo    (bus.d_addr[1:0]),
        .i_size       (bus.d_size),
        .i_signed     (bus.d_signed),
        .i_wdata      (bus.d_wdata),
        .i_rdata      (bus.mem_rdata),
        .o_misaligned (w_iss_mis),
        .o_be         (w_iss_be),
        .o_wdata      (w_iss_wdata),
        .o_rdata      (w_unused_iss_rdata)
    );

    lsu_align u_resp (
        .i_addr_lo    (r_addr_lo),
        .i_size       (r_size),
        .i_signed     (r_signed),
        .i_wdata      (32'h0),
        .i_rdata      (bus.mem_rdata),
        .o_misaligned (w_unused_rsp_mis),
        .o_be         (w_unused_rsp_be),
        .o_wdata      (w_unused_rsp_wdata),
        .o_rdata      (w_rsp_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr_lo <= 2'b00;
            r_size    <= 2'b00;
            r_signed  <= 1'b0;
            r_err     <= 1'b0;
            r_is_load <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_d_req) begin
                r_addr_lo <= bus.d_addr[1:0];
                r_size    <= bus.d_size;
                r_signed  <= bus.d_signed;
                r_err     <= w_iss_mis;
                r_is_load <= bus.d_rd;
            end
        end
    end

    // Everything is held at zero while reset is high so an issue cycle cut by reset writes nothing.
    always_comb begin
        w_next      = r_state;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_be    = 4'b0000;
        w_mem_wdata = 32'h0;
        w_if_valid  = 1'b0;
        w_if_rdata  = 32'h0;
        w_d_valid   = 1'b0;
        w_d_err     = 1'b0;
        w_d_rdata   = 32'h0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_d_req) begin
                        w_next = ST_D_RESP;
                        if (!w_iss_mis) begin
                            w_mem_en    = 1'b1;
                            w_mem_we    = bus.d_wr;
                            w_mem_addr  = bus.d_addr[AW+1:2];
                            w_mem_be    = w_iss_be;
                            w_mem_wdata = w_iss_wdata;
                        end
                    end else if (bus.if_req) begin
                        w_next     = ST_IF_RESP;
                        w_mem_en   = 1'b1;
                        w_mem_addr = bus.if_addr[AW+1:2];
                    end
                end
                ST_IF_RESP: begin
                    w_next     = ST_IDLE;
                    w_if_valid = 1'b1;
                    w_if_rdata = bus.mem_rdata;
                end
                ST_D_RESP: begin
                    w_next    = ST_IDLE;
                    w_d_valid = 1'b1;
                    w_d_err   = r_err;
                    if (r_is_load && !r_err) begin
                        w_d_rdata = w_rsp_rdata;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_be    = w_mem_be;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.if_valid  = w_if_valid;
    assign bus.if_rdata  = w_if_rdata;
    assign bus.d_valid   = w_d_valid;
    assign bus.d_err     = w_d_err;
    assign bus.d_rdata   = w_d_rdata;
    assign bus.stall     = ~rst & ((w_d_req & ~w_d_valid) | (bus.if_req & ~w_if_valid));
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
    localparam int AW    = 6;
    localparam int WORDS = 64;

    logic        clk;
    logic        rst;
    logic        tb_ld;
    logic [31:0] ram   [WORDS];
    logic [31:0] model [WORDS];
    int          checks;
    int          errors;

    unified_mem_arbiter_if #(.AW(AW)) bus ();

    unified_mem_arbiter #(.AW(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_ld) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= model[i];
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic legal_f(input logic [31:0] a, input logic [1:0] sz);
        return !(sz == 2'd3 || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0));
    endfunction

    function automatic int idx_f(input logic [31:0] a);
        return int'((a / 4) % WORDS);
    endfunction

    function automatic logic [3:0] be_f(input logic [31:0] a, input logic [1:0] sz);
        int lane = int'(a % 4);
        if (sz == 2'd0) return 4'(1 << lane);
        if (sz == 2'd1) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] load_f(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
        logic [31:0] v;
        v = model[idx_f(a)] >> (8 * (a % 4));
        if (sz == 2'd0) begin
            v = v % 256;
            if (sgn && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] repl_f(input logic [31:0] wd, input logic [1:0] sz);
        if (sz == 2'd0) return (wd % 256) * 32'h01010101;
        if (sz == 2'd1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int          lane = int'(a % 4);
        int          i    = idx_f(a);
        logic [3:0]  be   = be_f(a, sz);
        logic [31:0] byt;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                byt      = (wd >> (8 * (b - lane))) % 256;
                model[i] = (model[i] & ~(32'hFF << (8 * b))) | (byt << (8 * b));
            end
        end
    endtask

    task automatic data_op(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [1:0] sz, input logic sgn, input logic [31:0] wd);
        logic        legal = legal_f(a, sz);
        logic [31:0] exp_rd = (rd && legal) ? load_f(a, sz, sgn) : 32'h0;
        @(negedge clk);
        bus.d_rd = rd; bus.d_wr = wr; bus.d_addr = a;
        bus.d_size = sz; bus.d_signed = sgn; bus.d_wdata = wd;
        #1;
        chk("iss_stall", 32'(bus.stall), 32'd1);
        chk("iss_en", 32'(bus.mem_en), 32'(legal));
        if (legal) begin
            chk("iss_addr", 32'(bus.mem_addr), 32'(idx_f(a)));
            chk("iss_we", 32'(bus.mem_we), 32'(wr));
            if (wr) begin
                chk("iss_be", 32'(bus.mem_be), 32'(be_f(a, sz)));
                chk("iss_wdata", bus.mem_wdata, repl_f(wd, sz));
            end
        end
        @(posedge clk); #1;
        chk("rsp_valid", 32'(bus.d_valid), 32'd1);
        chk("rsp_err", 32'(bus.d_err), 32'(!legal));
        chk("rsp_rdata", bus.d_rdata, exp_rd);
        chk("rsp_stall", 32'(bus.stall), 32'd0);
        chk("rsp_if_rdata", bus.if_rdata, 32'h0);
        if (wr && legal) model_store(a, sz, wd);
        @(negedge clk);
        bus.d_rd = 1'b0; bus.d_wr = 1'b0;
    endtask

    task automatic fetch_op(input logic [31:0] a);
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = a;
        #1;
        chk("f_iss_stall", 32'(bus.stall), 32'd1);
        chk("f_iss_en", 32'(bus.mem_en), 32'd1);
        chk("f_iss_we", 32'(bus.mem_we), 32'd0);
        chk("f_iss_addr", 32'(bus.mem_addr), 32'(idx_f(a)));
        @(posedge clk); #1;
        chk("f_valid", 32'(bus.if_valid), 32'd1);
        chk("f_rdata", bus.if_rdata, model[idx_f(a)]);
        chk("f_stall", 32'(bus.stall), 32'd0);
        chk("f_d_valid", 32'(bus.d_valid), 32'd0);
        @(negedge clk);
        bus.if_req = 1'b0;
    endtask

    task automatic both_op(input logic [31:0] fa, input logic [31:0] da, input logic [1:0] sz, input logic sgn);
        logic        legal = legal_f(da, sz);
        logic [31:0] exp_rd = legal ? load_f(da, sz, sgn) : 32'h0;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = fa;
        bus.d_rd = 1'b1; bus.d_addr = da; bus.d_size = sz; bus.d_signed = sgn;
        #1;
        chk("b_n_stall", 32'(bus.stall), 32'd1);
        chk("b_n_en", 32'(bus.mem_en), 32'(legal));
        if (legal) chk("b_n_addr", 32'(bus.mem_addr), 32'(idx_f(da)));
        @(posedge clk); #1;
        chk("b_n1_dvalid", 32'(bus.d_valid), 32'd1);
        chk("b_n1_drdata", bus.d_rdata, exp_rd);
        chk("b_n1_ifvalid", 32'(bus.if_valid), 32'd0);
        chk("b_n1_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.d_rd = 1'b0;
        @(posedge clk); #1;
        chk("b_n2_dvalid", 32'(bus.d_valid), 32'd0);
        chk("b_n2_en", 32'(bus.mem_en), 32'd1);
        chk("b_n2_addr", 32'(bus.mem_addr), 32'(idx_f(fa)));
        chk("b_n2_stall", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        chk("b_n3_ifvalid", 32'(bus.if_valid), 32'd1);
        chk("b_n3_ifrdata", bus.if_rdata, model[idx_f(fa)]);
        chk("b_n3_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          kind;
        checks = 0; errors = 0;
        rst = 1'b1; tb_ld = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 32'h0;
        bus.d_size = 2'd0; bus.d_signed = 1'b0; bus.d_wdata = 32'h0;
        for (int i = 0; i < WORDS; i++) model[i] = $urandom;
        model[4] = 32'h8899AABB;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_dvalid", 32'(bus.d_valid), 32'd0);
        chk("rst_ifvalid", 32'(bus.if_valid), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_en", 32'(bus.mem_en), 32'd0);
        @(negedge clk);
        tb_ld = 1'b0; rst = 1'b0;

        data_op(1'b1, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
        data_op(1'b1, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
        data_op(1'b1, 1'b0, 32'h11, 2'd1, 1'b0, 32'h0);
        data_op(1'b0, 1'b1, 32'h12, 2'd0, 1'b0, 32'h000000C4);
        data_op(1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        chk("plan_reread", model[4], 32'h88C4AABB);
        both_op(32'h04, 32'h10, 2'd2, 1'b0);

        @(negedge clk);
        bus.d_wr = 1'b1; bus.d_addr = 32'h10; bus.d_size = 2'd2; bus.d_wdata = 32'hDEADBEEF;
        #1;
        chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_en2", 32'(bus.mem_en), 32'd0);
        chk("rst_stall2", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        chk("rst_dvalid2", 32'(bus.d_valid), 32'd0);
        @(negedge clk);
        bus.d_wr = 1'b0; rst = 1'b0;
        data_op(1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);

        @(negedge clk);
        bus.d_rd = 1'b1; bus.d_addr = 32'h10; bus.d_size = 2'd2;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_dvalid", 32'(bus.d_valid), 32'd0);
        chk("mid_rst_drdata", bus.d_rdata, 32'h0);
        @(negedge clk);
        bus.d_rd = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_dvalid", 32'(bus.d_valid), 32'd0);

        fetch_op(32'(4 * WORDS + 8));

        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 3));
            a    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
            sz   = 2'($urandom_range(0, 3));
            case (kind)
                0: data_op(1'b1, 1'b0, a, sz, 1'($urandom_range(0, 1)), 32'h0);
                1: data_op(1'b0, 1'b1, a, sz, 1'b0, $urandom);
                2: fetch_op(a);
                default: both_op($urandom, a, sz, 1'($urandom_range(0, 1)));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
